// File: rtl/fetch_unit.sv
// Front-end fetch stage: PC generation, single-outstanding instruction memory requests and an in-order fetch queue.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned Q_DEPTH  = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        freeze,
    input  logic        flush,
    input  logic        branch_miss,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_frozen
);

    localparam int unsigned PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          outstanding_q, outstanding_d;
    logic          discard_q, discard_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   q_pc_q    [Q_DEPTH];
    logic [31:0]   q_pc_d    [Q_DEPTH];
    logic [31:0]   q_instr_q [Q_DEPTH];
    logic [31:0]   q_instr_d [Q_DEPTH];
    logic          fetch_valid_q, fetch_valid_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   fetch_instr_q, fetch_instr_d;

    logic redirect_s;
    logic imem_req_s;
    logic grant_s;
    logic rvalid_ok_s;
    logic write_s;
    logic consume_s;
    logic redirect_pc_unused_s;

    // The low address bits of a redirect target are dropped to keep fetches word aligned.
    assign redirect_pc_unused_s = ^redirect_pc[1:0];

    // Next-state for PC, request tracking, queue and registered head outputs.
    always_comb begin
        redirect_s  = flush | branch_miss;
        imem_req_s  = nRST && !outstanding_q && (count_q < CW'(Q_DEPTH)) && !redirect_s;
        grant_s     = imem_req_s && imem_gnt;
        rvalid_ok_s = imem_rvalid && outstanding_q;
        write_s     = rvalid_ok_s && !discard_q && !redirect_s;
        consume_s   = fetch_valid_q && !freeze && !redirect_s;

        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        q_pc_d        = q_pc_q;
        q_instr_d     = q_instr_q;

        if (redirect_s) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            wr_ptr_d = PW'(0);
            rd_ptr_d = PW'(0);
            count_d  = CW'(0);
            // A response still in flight belongs to the old path and must be swallowed later.
            if (rvalid_ok_s) begin
                outstanding_d = 1'b0;
                discard_d     = 1'b0;
            end else if (outstanding_q) begin
                discard_d = 1'b1;
            end else begin
                discard_d = discard_q;
            end
        end else begin
            if (grant_s) begin
                outstanding_d = 1'b1;
                pc_d          = pc_q + 32'd4;
                req_pc_d      = pc_q;
            end else if (rvalid_ok_s) begin
                outstanding_d = 1'b0;
                discard_d     = 1'b0;
            end else begin
                outstanding_d = outstanding_q;
            end

            if (write_s) begin
                q_pc_d[wr_ptr_q]    = req_pc_q;
                q_instr_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d            = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (consume_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            count_d = count_q + CW'(write_s) - CW'(consume_s);
        end

        fetch_valid_d = (count_d != CW'(0));
        if (fetch_valid_d) begin
            fetch_pc_d    = q_pc_d[rd_ptr_d];
            fetch_instr_d = q_instr_d[rd_ptr_d];
        end else begin
            fetch_pc_d    = 32'h0000_0000;
            fetch_instr_d = 32'h0000_0000;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            wr_ptr_q      <= PW'(0);
            rd_ptr_q      <= PW'(0);
            count_q       <= CW'(0);
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= 32'h0000_0000;
            fetch_instr_q <= 32'h0000_0000;
            for (int i = 0; i < int'(Q_DEPTH); i++) begin
                q_pc_q[i]    <= 32'h0000_0000;
                q_instr_q[i] <= 32'h0000_0000;
            end
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_instr_q <= fetch_instr_d;
            q_pc_q        <= q_pc_d;
            q_instr_q     <= q_instr_d;
        end
    end

    assign imem_req    = imem_req_s;
    assign imem_addr   = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    assign fetch_instr = fetch_instr_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_frozen_q, perf_frozen_d;

    // Counter increments; a redirect-suppressed head is not a consume.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_frozen_d  = perf_frozen_q;
        if (consume_s) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end else begin
            perf_fetched_d = perf_fetched_q;
        end
        if (fetch_valid_q && freeze) begin
            perf_frozen_d = perf_frozen_q + 32'd1;
        end else begin
            perf_frozen_d = perf_frozen_q;
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_fetched_q <= 32'h0000_0000;
            perf_frozen_q  <= 32'h0000_0000;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_frozen_q  <= perf_frozen_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_frozen  = perf_frozen_q;
`else
    assign perf_fetched = 32'h0000_0000;
    assign perf_frozen  = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table for reset/stream/freeze, scoreboard of expected
// consumed entries, and hand sequences for flush, branch miss, PC wrap, late rvalid and perf counters.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        branch_miss = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic [31:0] perf_fetched;
    logic [31:0] perf_frozen;

    fetch_unit dut (
        .CLK(CLK), .nRST(nRST),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .freeze(freeze), .flush(flush), .branch_miss(branch_miss), .redirect_pc(redirect_pc),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .perf_fetched(perf_fetched), .perf_frozen(perf_frozen)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        gnt;
        logic        frz;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    vec_t        tbl [20];
    ent_t        sb [$];
    int          n_checks = 0;
    int          n_pass = 0;
    bit          grant_seen = 1'b0;
    logic [31:0] gaddr = 32'h0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;
    int          mem_lat = 1;
    bit          const_data = 1'b1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return const_data ? 32'h0000_0013 : (a ^ 32'h1357_0013);
    endfunction

    function automatic vec_t mk(input logic g, input logic f, input logic r, input logic [31:0] a,
                                input logic v, input logic [31:0] p, input logic [31:0] i);
        vec_t x;
        x.gnt = g; x.frz = f; x.req = r; x.addr = a; x.valid = v; x.pc = p; x.instr = i;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic push(input logic [31:0] pc);
        ent_t e;
        e.pc = pc;
        e.instr = instr_of(pc);
        sb.push_back(e);
    endtask

    // Negedge: scoreboard pops on consume, and the grant decision is captured for the memory model.
    task automatic sample();
        ent_t e;
        @(negedge CLK);
        if (fetch_valid && !freeze && !flush && !branch_miss) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_consume", $sformatf("got pc %h, required no entry", fetch_pc));
            end else begin
                e = sb.pop_front();
                check("consume_pc", fetch_pc, e.pc);
                check("consume_instr", fetch_instr, e.instr);
            end
        end
        grant_seen = imem_req && imem_gnt;
        gaddr = imem_addr;
    endtask

    // Just after posedge: memory model answers a granted request after mem_lat cycles.
    task automatic advance();
        @(posedge CLK);
        #1;
        imem_rvalid = 1'b0;
        if (grant_seen) begin
            pend = 1'b1;
            pend_addr = gaddr;
            pend_cnt = mem_lat;
        end
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata = instr_of(pend_addr);
                pend = 1'b0;
            end
        end
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        flush = 1'b0; branch_miss = 1'b0; freeze = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; redirect_pc = 32'h0;
        pend = 1'b0; grant_seen = 1'b0;
        sb.delete();
        tick();
        sample();
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, fetch_valid}, 32'h0);
        check("rst_pc", fetch_pc, 32'h0);
        check("rst_instr", fetch_instr, 32'h0);
        check("rst_perf_fetched", perf_fetched, 32'h0);
        check("rst_perf_frozen", perf_frozen, 32'h0);
        advance();
        nRST = 1'b1;
    endtask

    task automatic wait_grant(input logic [31:0] exp, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            sample();
            if (grant_seen) begin
                check("grant_addr", gaddr, exp);
                done = 1'b1;
            end
            advance();
        end
        if (!done) fail_now("grant_timeout", $sformatf("got no grant, required grant at %h", exp));
    endtask

    task automatic wait_sb_empty(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick();
        check("sb_drained", sb.size(), 32'h0);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            imem_gnt = tbl[i].gnt;
            freeze = tbl[i].frz;
            sample();
            check($sformatf("row%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
            check($sformatf("row%0d_addr", i), imem_addr, tbl[i].addr);
            check($sformatf("row%0d_valid", i), {31'b0, fetch_valid}, {31'b0, tbl[i].valid});
            check($sformatf("row%0d_pc", i), fetch_pc, tbl[i].pc);
            check($sformatf("row%0d_instr", i), fetch_instr, tbl[i].instr);
            advance();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1);
    end

    initial begin
        // Reset release, streaming with 1-cycle memory: grant N -> valid N+2, one word per 2 cycles.
        tbl[0]  = mk(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 32'h0, 32'h13);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 32'h8, 1'b0, 32'h0, 32'h0);
        tbl[4]  = mk(1'b1, 1'b0, 1'b1, 32'h8, 1'b1, 32'h4, 32'h13);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 32'hC, 1'b0, 32'h0, 32'h0);
        tbl[6]  = mk(1'b1, 1'b0, 1'b1, 32'hC, 1'b1, 32'h8, 32'h13);
        // Freeze for 10 cycles: two entries buffer, requests stop, then drain without refetch.
        tbl[7]  = mk(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        tbl[8]  = mk(1'b1, 1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0);
        tbl[9]  = mk(1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'h13);
        for (int i = 10; i <= 16; i++) tbl[i] = mk(1'b1, 1'b1, 1'b0, 32'h8, 1'b1, 32'h0, 32'h13);
        tbl[17] = mk(1'b0, 1'b0, 1'b0, 32'h8, 1'b1, 32'h0, 32'h13);
        tbl[18] = mk(1'b0, 1'b0, 1'b1, 32'h8, 1'b1, 32'h4, 32'h13);
        tbl[19] = mk(1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);

        const_data = 1'b1;
        mem_lat = 1;
        do_reset();
        push(32'h0); push(32'h4); push(32'h8);
        run_rows(0, 6);
        check("t1_drained", sb.size(), 32'h0);

        do_reset();
        push(32'h0); push(32'h4);
        run_rows(7, 19);
        check("t2_drained", sb.size(), 32'h0);

        // Flush while the request to 0x8 is outstanding (2-cycle memory).
        const_data = 1'b0;
        mem_lat = 2;
        do_reset();
        imem_gnt = 1'b1;
        push(32'h0); push(32'h4); push(32'h100);
        wait_grant(32'h0, 4);
        wait_grant(32'h4, 6);
        wait_grant(32'h8, 6);
        flush = 1'b1;
        redirect_pc = 32'h100;
        sample();
        check("flush_req", {31'b0, imem_req}, 32'h0);
        advance();
        flush = 1'b0;
        wait_grant(32'h100, 6);
        imem_gnt = 1'b0;
        wait_sb_empty(10);

        // Branch miss coinciding with rvalid and a would-be consume; low target bits dropped.
        mem_lat = 1;
        do_reset();
        freeze = 1'b1;
        imem_gnt = 1'b1;
        repeat (3) tick();
        freeze = 1'b0;
        branch_miss = 1'b1;
        redirect_pc = 32'h2002;
        push(32'h2000);
        sample();
        check("bm_valid_before", {31'b0, fetch_valid}, 32'h1);
        check("bm_req", {31'b0, imem_req}, 32'h0);
        advance();
        branch_miss = 1'b0;
        sample();
        check("bm_valid_after", {31'b0, fetch_valid}, 32'h0);
        check("bm_req_after", {31'b0, imem_req}, 32'h1);
        check("bm_addr_after", imem_addr, 32'h2000);
        advance();
        imem_gnt = 1'b0;
        wait_sb_empty(8);

        // PC wrap from the top of the address space.
        flush = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        imem_gnt = 1'b1;
        push(32'hFFFF_FFFC); push(32'h0);
        wait_grant(32'hFFFF_FFFC, 4);
        wait_grant(32'h0, 6);
        imem_gnt = 1'b0;
        wait_sb_empty(8);

        // Stray rvalid with nothing outstanding is ignored.
        do_reset();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        sample();
        check("stray_rv_valid", {31'b0, fetch_valid}, 32'h0);
        check("stray_rv_req", {31'b0, imem_req}, 32'h1);
        advance();

        // Five consumes and three frozen-valid cycles, then a reset pulse.
        do_reset();
        freeze = 1'b1;
        imem_gnt = 1'b1;
        push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10);
        repeat (5) tick();
        freeze = 1'b0;
        wait_grant(32'h8, 4);
        wait_grant(32'hC, 6);
        wait_grant(32'h10, 6);
        imem_gnt = 1'b0;
        wait_sb_empty(10);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'd5);
        check("perf_frozen", perf_frozen, 32'd3);
`else
        check("perf_fetched_tied", perf_fetched, 32'd0);
        check("perf_frozen_tied", perf_frozen, 32'd0);
`endif
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch stage that generates the program counter, requests instruction words from instruction memory and presents them in order to the scoreboard's fetch input. It is the producer side of the scoreboard's fetch/freeze/flush handshake. It stalls on `freeze`, redirects on `flush`/`branch_miss`, and buffers returned words in a small in-order queue.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `Q_DEPTH`, 2: fetch queue entries, power of two, 2..8.
- `CLK`  in  1: clock, all state updates on the rising edge.
- `nRST`  in  1: asynchronous active-low reset.
- `imem_req`  out  1: instruction read request, held until accepted.
- `imem_addr`  out  32: word-aligned request address, stable while `imem_req`.
- `imem_gnt`  in  1: request accepted this cycle.
- `imem_rvalid`  in  1: read data valid, in order, one per accepted request.
- `imem_rdata`  in  32: instruction word.
- `freeze`  in  1: scoreboard cannot accept the head entry this cycle.
- `flush`  in  1: discard all fetched state and redirect.
- `branch_miss`  in  1: misprediction, redirect (same effect as `flush`).
- `redirect_pc`  in  32: target used on `flush` or `branch_miss`.
- `fetch_valid`  out  1: head entry valid.
- `fetch_pc`  out  32: PC of the head entry.
- `fetch_instr`  out  32: instruction of the head entry.
- `perf_fetched`  out  32: count of entries consumed (only with `FETCH_PERF_CNT_EN`).
- `perf_frozen`  out  32: count of cycles with `fetch_valid && freeze` (only with `FETCH_PERF_CNT_EN`).

## Operation
- State: `pc`, `outstanding` (0/1), `discard` (1 bit), queue of `Q_DEPTH` {pc, instr} entries with read and write pointers and a count.
- Reset values: `pc=RESET_PC`, `outstanding=0`, `discard=0`, queue empty. Outputs: `imem_req=0`, `imem_addr=RESET_PC`, `fetch_valid=0`, `fetch_pc=0`, `fetch_instr=0`, perf counters 0.
- At most one outstanding request. `imem_req=1` when `outstanding==0` and `count + outstanding < Q_DEPTH` and no redirect this cycle. `imem_addr=pc`.
- Request accepted (`imem_req && imem_gnt`): `outstanding<=1`, `pc<=pc+4` (wraps modulo 2^32).
- `imem_rvalid` while `outstanding`: `outstanding<=0`. If `discard=1`, drop the data and clear `discard`. Otherwise write {request pc, `imem_rdata`} at the tail. The request pc is latched at grant.
- Head is presented while count>0. It is consumed on a cycle with `fetch_valid && !freeze`, and the read pointer advances. A consume and a write in the same cycle keep the count unchanged, and the write still succeeds when full-minus-one.
- Redirect (`flush || branch_miss`) has priority over everything:
  - The queue empties, and the same-cycle write and consume are suppressed.
  - `pc<=redirect_pc`.
  - `imem_req` is forced to 0 that cycle.
  - If a request is outstanding and its `imem_rvalid` is not in this same cycle, set `discard=1`.
  - If `rvalid` arrives in the redirect cycle, the data is dropped and `outstanding` clears.
- `imem_rvalid` with `outstanding==0` is a protocol error and is ignored.
- `redirect_pc[1:0]` is ignored (forced to 0).

## Timing
- Request granted in cycle N, earliest `imem_rvalid` in N+1, entry visible on `fetch_valid` in N+2. Best-case redirect-to-`fetch_valid` latency is 3 cycles.
- Outputs are registered. `imem_req` is combinational from registered state and the same-cycle redirect inputs.
- Sustained throughput with 1-cycle memory and one outstanding request: one word every 2 cycles.
- `freeze` stalls only consumption. Fetching continues until the queue plus the outstanding request reach `Q_DEPTH`.
- When `nRST` is asserted mid-transaction, all state returns to reset values immediately. A late `imem_rvalid` after reset release is ignored because `outstanding=0`.

## Configuration
- `FETCH_PERF_CNT_EN` defined: `perf_fetched` increments on each consume, and `perf_frozen` increments on each cycle with `fetch_valid && freeze`. Both are 32-bit, wrap, and are cleared only by `nRST`.
- `FETCH_PERF_CNT_EN` undefined: both ports tie to 0 and no counter flops exist.

## Test plan
- Reset release, memory returns 0x13 for each request with `gnt=1` and 1-cycle `rvalid`, no freeze:
  - Required: `fetch_pc` sequence 0x0, 0x4, 0x8 with `fetch_instr=0x13`.
  - First `fetch_valid` appears 2 cycles after the first grant.
- Hold `freeze=1` for 10 cycles with `Q_DEPTH=2`:
  - Required: exactly 2 entries buffered and `imem_req` stays 0 afterwards.
  - On release, the entries drain in order 0x0, 0x4, with no loss or duplication.
- Assert `flush` with `redirect_pc=0x100` while a request to 0x8 is outstanding:
  - Required: the 0x8 response is discarded.
  - The next `imem_addr=0x100`, and the first post-flush `fetch_pc=0x100`.
- Assert `branch_miss` in the same cycle as `imem_rvalid` and a consume, with `redirect_pc=0x2002`:
  - Required: the queue is empty next cycle and `outstanding=0`.
  - The next request address is 0x2000.
- Set `pc=0xFFFF_FFFC` via redirect, then fetch twice:
  - Required: `fetch_pc` 0xFFFF_FFFC then 0x0000_0000.
- With `FETCH_PERF_CNT_EN`, 5 consumes and 3 frozen-valid cycles:
  - Required: `perf_fetched=5` and `perf_frozen=3`.
  - A mid-run `nRST` pulse returns both to 0.
